dvi_timing_ctrl: RTL and testbench
==================================

DVI_TIMING_CTRL -- requirements
Module: dvi_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0, sync asserted level (0 = active-low).
REQ-010 SHALL have ports: clk_pix in 1, pixel clock, the only clock; rst_pix_n in 1, reset, asynchronous assert, active-low.
REQ-011 SHALL have ports: enable in 1, run timing; clr_err in 1, clear err_sticky.
REQ-012 SHALL have ports: s_valid in 1, s_first in 1 (pixel is frame origin), s_data in 24 ({R,G,B}), s_ready out 1.
REQ-013 SHALL have ports: de out 1; data_ch0/ch1/ch2 out 8 each (B/G/R); ctrl_ch0 out 2 ({vsync,hsync}); ctrl_ch1, ctrl_ch2 out 2 each.
REQ-014 SHALL have ports: frame_start out 1 (pulse); err_sticky out 1 (underflow or misalignment seen).

Function
REQ-015 SHALL keep h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params); h_cnt wraps to 0 and v_cnt increments, v_cnt wraps to 0 after V_TOTAL-1.
REQ-016 SHALL size both counters to $clog2 of their totals; no overflow is permitted for any legal parameter set.
REQ-017 SHALL treat position active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; hsync when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync on lines V_ACTIVE+V_FP .. V_ACTIVE+V_FP+V_SYNC-1.
REQ-018 SHALL register all outputs: de/ctrl/data for position (h,v) appear exactly one clk_pix after the counters hold (h,v).
REQ-019 SHALL drive sync outputs as SYNC_POL when asserted and ~SYNC_POL otherwise; ctrl_ch1 = ctrl_ch2 = 2'b00 always.
REQ-020 SHALL implement FSM states IDLE, WAIT_SOF, RUN.
REQ-021 IDLE: counters held at 0, s_ready=0, de=0, data=0, syncs deasserted; enable=1 moves to WAIT_SOF.
REQ-022 enable=0 in any state SHALL move to IDLE on the next edge, clearing counters, regardless of frame position.
REQ-023 WAIT_SOF: counters run and syncs are generated; de=0 and data=0 throughout.
REQ-024 WAIT_SOF: s_ready=1 while s_valid=1 and s_first=0, so stale pixels are discarded.
REQ-025 WAIT_SOF: s_ready=0 while head has s_first=1; head is held.
REQ-026 WAIT_SOF -> RUN when counters are at (0,0) and a head with s_first=1 is valid; that head is consumed at (0,0).
REQ-027 RUN: s_ready=1 exactly on active positions; transfer on s_valid&s_ready; de=1 and data = transferred pixel.
REQ-028 Underflow (RUN, active position, s_valid=0): SHALL output de=1 with data 0, set err_sticky, and go to WAIT_SOF.
REQ-029 Misalignment (RUN, active position other than (0,0), s_first=1): pixel is not consumed (s_ready=0 that cycle), data 0 is output, err_sticky is set, and the FSM goes to WAIT_SOF.
REQ-030 frame_start SHALL pulse for one cycle, aligned with output position (0,0), whenever the state is not IDLE.
REQ-031 err_sticky SHALL clear on clr_err; simultaneous set and clr_err SHALL leave it set.

Reset
REQ-032 SHALL, when rst_pix_n is low, asynchronously force: state IDLE, counters 0, s_ready 0, de 0, data 0, syncs deasserted (~SYNC_POL), frame_start 0, err_sticky 0.
REQ-033 SHALL release reset synchronously on the first clk_pix edge after rst_pix_n is high; a mid-frame reset restarts at (0,0) in IDLE.

Verification (H 4/1/2/1, V 3/1/1/1, SYNC_POL 0; totals 8x6)
REQ-034 Reset then enable=1, continuous valid stream with s_first on pixel 0 -> 12 de cycles per frame, hsync low for h=5..6, vsync low on line 4, frame_start period 48 cycles.
REQ-035 Three pixels without s_first precede a frame -> all three consumed in WAIT_SOF with de=0; first displayed pixel is the s_first pixel at (0,0).
REQ-036 s_valid dropped at (2,1) -> output de=1 with data 0 there, err_sticky=1, no further de until the next (0,0) with s_first.
REQ-037 s_first presented at (3,0) in RUN -> not consumed, err_sticky=1, the held pixel is displayed at the next (0,0).
REQ-038 enable=0 at (1,2), and separately rst_pix_n low mid-line -> outputs reach reset values (asynchronously for reset, next edge for enable) and counters restart at (0,0).
REQ-039 clr_err asserted in the same cycle as an underflow -> err_sticky stays 1; clr_err alone the next cycle -> 0.

Source files
------------

// File: rtl/dvi_timing_ctrl.sv
// DVI timing controller: raster counters, sync generation and a ready/valid pixel
// input that locks to the frame origin through s_first.
module dvi_timing_ctrl #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        clk_pix,
    input  logic        rst_pix_n,
    input  logic        enable,
    input  logic        clr_err,
    input  logic        s_valid,
    input  logic        s_first,
    input  logic [23:0] s_data,
    output logic        s_ready,
    output logic        de,
    output logic [7:0]  data_ch0,
    output logic [7:0]  data_ch1,
    output logic [7:0]  data_ch2,
    output logic [1:0]  ctrl_ch0,
    output logic [1:0]  ctrl_ch1,
    output logic [1:0]  ctrl_ch2,
    output logic        frame_start,
    output logic        err_sticky
);

    // state    | meaning
    // IDLE     | timing stopped, counters parked at (0,0), outputs quiet
    // WAIT_SOF | raster and syncs running, stale pixels dropped until s_first at (0,0)
    // RUN      | pixels consumed on every active position and shown with de=1

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic          SYNC_OFF = ~SYNC_POL;
    localparam logic [1:0]    CTRL_OFF = {SYNC_OFF, SYNC_OFF};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   h_q, h_d, h_adv;
    logic [VW-1:0]   v_q, v_d, v_adv;
    logic            de_q, de_d;
    logic [23:0]     pix_q, pix_d;
    logic [1:0]      ctrl_q, ctrl_d;
    logic            fs_q, fs_d;
    logic            err_q, err_d;
    logic            err_set;
    logic            ready_c;

    logic [31:0]     h_pos, v_pos;
    logic            in_active, at_origin, hs_win, vs_win;
    logic [1:0]      ctrl_run;

    // Compare in 32 bits so sync windows ending exactly at the line total stay correct.
    assign h_pos     = 32'(h_q);
    assign v_pos     = 32'(v_q);
    assign in_active = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
    assign at_origin = (h_q == '0) && (v_q == '0);
    assign hs_win    = (h_pos >= HS_BEG) && (h_pos < HS_END);
    assign vs_win    = (v_pos >= VS_BEG) && (v_pos < VS_END);
    assign ctrl_run  = {(vs_win ? SYNC_POL : SYNC_OFF), (hs_win ? SYNC_POL : SYNC_OFF)};

    always_comb begin
        h_adv = h_q + HW'(1);
        v_adv = v_q;
        if (h_q == H_LAST) begin
            h_adv = '0;
            v_adv = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        ready_c = 1'b0;
        de_d    = 1'b0;
        pix_d   = '0;
        ctrl_d  = CTRL_OFF;
        fs_d    = 1'b0;
        err_set = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT_SOF;
                end

                ST_WAIT_SOF: begin
                    h_d    = h_adv;
                    v_d    = v_adv;
                    ctrl_d = ctrl_run;
                    fs_d   = at_origin;
                    if (at_origin && s_valid && s_first) begin
                        ready_c = 1'b1;
                        de_d    = 1'b1;
                        pix_d   = s_data;
                        state_d = ST_RUN;
                    end else begin
                        ready_c = s_valid & ~s_first;
                    end
                end

                ST_RUN: begin
                    h_d    = h_adv;
                    v_d    = v_adv;
                    ctrl_d = ctrl_run;
                    fs_d   = at_origin;
                    if (in_active) begin
                        de_d    = 1'b1;
                        // A frame head arriving early is left in place for the next origin.
                        ready_c = ~(s_first & ~at_origin);
                        if (!s_valid || (s_first && !at_origin)) begin
                            err_set = 1'b1;
                            state_d = ST_WAIT_SOF;
                        end else begin
                            pix_d = s_data;
                        end
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    h_d     = '0;
                    v_d     = '0;
                end
            endcase
        end

        err_d = err_set | (err_q & ~clr_err);
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q <= ST_IDLE;
            h_q     <= '0;
            v_q     <= '0;
            de_q    <= 1'b0;
            pix_q   <= '0;
            ctrl_q  <= CTRL_OFF;
            fs_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            de_q    <= de_d;
            pix_q   <= pix_d;
            ctrl_q  <= ctrl_d;
            fs_q    <= fs_d;
            err_q   <= err_d;
        end
    end

    assign s_ready     = ready_c;
    assign de          = de_q;
    assign data_ch0    = pix_q[7:0];
    assign data_ch1    = pix_q[15:8];
    assign data_ch2    = pix_q[23:16];
    assign ctrl_ch0    = ctrl_q;
    assign ctrl_ch1    = 2'b00;
    assign ctrl_ch2    = 2'b00;
    assign frame_start = fs_q;
    assign err_sticky  = err_q;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// Bench for dvi_timing_ctrl on an 8x6 raster: hand-computed start-up vectors,
// then a reference model feeding a scoreboard, plus directed corner cases.
`timescale 1ns/1ps
module tb_dvi_timing_ctrl;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk_pix = 1'b0;
    logic        rst_pix_n = 1'b1;
    logic        enable = 1'b0, clr_err = 1'b0, s_valid = 1'b0, s_first = 1'b0;
    logic [23:0] s_data = '0;
    logic        s_ready, de, frame_start, err_sticky;
    logic [7:0]  data_ch0, data_ch1, data_ch2;
    logic [1:0]  ctrl_ch0, ctrl_ch1, ctrl_ch2;

    dvi_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .enable(enable), .clr_err(clr_err),
        .s_valid(s_valid), .s_first(s_first), .s_data(s_data), .s_ready(s_ready),
        .de(de), .data_ch0(data_ch0), .data_ch1(data_ch1), .data_ch2(data_ch2),
        .ctrl_ch0(ctrl_ch0), .ctrl_ch1(ctrl_ch1), .ctrl_ch2(ctrl_ch2),
        .frame_start(frame_start), .err_sticky(err_sticky)
    );

    always #5 clk_pix = ~clk_pix;

    typedef struct {
        logic        de;
        logic [23:0] data;
        logic [1:0]  ctrl;
        logic        fs;
        logic        err;
    } out_t;

    typedef struct {
        logic        en, sv, sf;
        logic [23:0] d;
        logic        clr;
        logic        x_rdy, x_de;
        logic [23:0] x_data;
        logic [1:0]  x_ctrl;
        logic        x_fs, x_err;
    } vec_t;

    out_t sbq[$];
    int   total = 0, bad = 0;
    int   cyc_n = 0, n_de = 0, n_hs = 0, n_vs = 0, last_fs = -1, fs_gap = 0;
    int   m_st = 0, mh = 0, mv = 0;
    logic m_err = 1'b0;
    int   src_fr = 0, src_k = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; mh = 0; mv = 0; m_err = 1'b0;
        sbq.delete();
    endtask

    // Reference model: one call per clock, returns s_ready for this cycle and
    // the outputs the DUT must show after the coming edge.
    task automatic model_step(input logic en, input logic sv, input logic sf,
                              input logic [23:0] d, input logic clr,
                              output logic rdy, output out_t o);
        logic vis, org, seterr;
        vis    = (mh < HA) && (mv < VA);
        org    = (mh == 0) && (mv == 0);
        rdy    = 1'b0;
        seterr = 1'b0;
        o.de = 1'b0; o.data = '0; o.ctrl = 2'b11; o.fs = 1'b0;
        if (!en) begin
            m_st = 0; mh = 0; mv = 0;
        end else if (m_st == 0) begin
            m_st = 1;
        end else begin
            o.ctrl = {~(mv >= VA + VF && mv < VA + VF + VS), ~(mh >= HA + HF && mh < HA + HF + HS)};
            o.fs   = org;
            if (m_st == 1) begin
                if (org && sv && sf) begin
                    rdy = 1'b1; o.de = 1'b1; o.data = d; m_st = 2;
                end else begin
                    rdy = sv && !sf;
                end
            end else if (vis) begin
                o.de = 1'b1;
                rdy  = !(sf && !org);
                if (!sv || (sf && !org)) begin
                    seterr = 1'b1; m_st = 1;
                end else begin
                    o.data = d;
                end
            end
            mh++;
            if (mh == HT) begin
                mh = 0; mv++;
                if (mv == VT) mv = 0;
            end
        end
        m_err = seterr | (m_err & ~clr);
        o.err = m_err;
    endtask

    task automatic cyc(input logic en, input logic sv, input logic sf, input logic [23:0] d,
                       input logic clr, input logic use_x, input logic x_rdy, input out_t x,
                       output logic rdy);
        out_t e;
        enable = en; s_valid = sv; s_first = sf; s_data = d; clr_err = clr;
        model_step(en, sv, sf, d, clr, rdy, e);
        if (use_x) begin
            rdy = x_rdy;
            e   = x;
        end
        sbq.push_back(e);
        #1 chk("s_ready", {31'd0, s_ready}, {31'd0, rdy});
        @(posedge clk_pix);
        #1;
        cyc_n++;
        e = sbq.pop_front();
        chk("de", {31'd0, de}, {31'd0, e.de});
        chk("data", {8'd0, data_ch2, data_ch1, data_ch0}, {8'd0, e.data});
        chk("ctrl_ch0", {30'd0, ctrl_ch0}, {30'd0, e.ctrl});
        chk("ctrl_ch12", {28'd0, ctrl_ch1, ctrl_ch2}, 32'd0);
        chk("frame_start", {31'd0, frame_start}, {31'd0, e.fs});
        chk("err_sticky", {31'd0, err_sticky}, {31'd0, e.err});
        if (de) n_de++;
        if (ctrl_ch0[0] == 1'b0) n_hs++;
        if (ctrl_ch0[1] == 1'b0) n_vs++;
        if (frame_start) begin
            if (last_fs >= 0) fs_gap = cyc_n - last_fs;
            last_fs = cyc_n;
        end
    endtask

    function automatic logic [23:0] src_pix(input int fr, input int k);
        return {8'(fr), 8'(k), 8'hC3 ^ 8'(k)};
    endfunction

    task automatic scyc(input logic en, input logic drop, input logic clr);
        logic r, sv;
        out_t none;
        none = '{de: 1'b0, data: '0, ctrl: 2'b11, fs: 1'b0, err: 1'b0};
        sv = !drop;
        cyc(en, sv, (src_k == 0), src_pix(src_fr, src_k), clr, 1'b0, 1'b0, none, r);
        if (sv && r) begin
            src_k++;
            if (src_k == HA * VA) begin
                src_k = 0; src_fr++;
            end
        end
    endtask

    task automatic run_to(input int h, input int v);
        for (int i = 0; i < 2 * HT * VT && !(mh == h && mv == v); i++) scyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_de"}, {31'd0, de}, 32'd0);
        chk({tag, "_data"}, {8'd0, data_ch2, data_ch1, data_ch0}, 32'd0);
        chk({tag, "_ctrl"}, {30'd0, ctrl_ch0}, 32'd3);
        chk({tag, "_fs"}, {31'd0, frame_start}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[9];
        out_t xo;
        logic r;
        logic [23:0] held;

        // Start-up: three stale pixels dropped, frame head then held until (0,0).
        tbl[0] = '{1'b1, 1'b1, 1'b0, 24'hDEAD01, 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 24'hDEAD01, 1'b0, 1'b1, 1'b0, 24'h0, 2'b11, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 24'hDEAD02, 1'b0, 1'b1, 1'b0, 24'h0, 2'b11, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 24'hDEAD03, 1'b0, 1'b1, 1'b0, 24'h0, 2'b11, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 24'h0000C3, 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 24'h0000C3, 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 24'h0000C3, 1'b0, 1'b0, 1'b0, 24'h0, 2'b10, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 24'h0000C3, 1'b0, 1'b0, 1'b0, 24'h0, 2'b10, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 24'h0000C3, 1'b0, 1'b0, 1'b0, 24'h0, 2'b11, 1'b0, 1'b0};

        model_reset();
        #2 rst_pix_n = 1'b0;
        #1;
        chk_quiet("rst_async");
        chk("rst_err", {31'd0, err_sticky}, 32'd0);
        chk("rst_ready", {31'd0, s_ready}, 32'd0);
        repeat (2) @(posedge clk_pix);
        #1 rst_pix_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            xo = '{de: tbl[i].x_de, data: tbl[i].x_data, ctrl: tbl[i].x_ctrl,
                   fs: tbl[i].x_fs, err: tbl[i].x_err};
            cyc(tbl[i].en, tbl[i].sv, tbl[i].sf, tbl[i].d, tbl[i].clr, 1'b1, tbl[i].x_rdy, xo, r);
        end

        // Head of frame 0 is still presented; stream from the source from here on.
        src_fr = 0; src_k = 0;
        run_to(0, 0);
        n_de = 0; n_hs = 0; n_vs = 0; last_fs = -1; fs_gap = 0;
        scyc(1'b1, 1'b0, 1'b0);
        chk("first_pix_de", {31'd0, de}, 32'd1);
        chk("first_pix_data", {8'd0, data_ch2, data_ch1, data_ch0}, 32'h0000C3);
        for (int i = 1; i < 2 * HT * VT; i++) scyc(1'b1, 1'b0, 1'b0);
        chk("de_count_2frames", n_de, 24);
        chk("hsync_low_2frames", n_hs, 24);
        chk("vsync_low_2frames", n_vs, 16);
        chk("frame_start_period", fs_gap, 48);

        // Underflow at (2,1).
        run_to(2, 1);
        scyc(1'b1, 1'b1, 1'b0);
        chk("uf_de", {31'd0, de}, 32'd1);
        chk("uf_data", {8'd0, data_ch2, data_ch1, data_ch0}, 32'd0);
        chk("uf_err", {31'd0, err_sticky}, 32'd1);
        n_de = 0;
        run_to(0, 0);
        chk("uf_no_de_until_sof", n_de, 0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("uf_resync_de", {31'd0, de}, 32'd1);

        // Early frame head at (3,0).
        scyc(1'b1, 1'b0, 1'b1);
        chk("clr_err", {31'd0, err_sticky}, 32'd0);
        run_to(3, 0);
        src_k = 0; src_fr++;
        held = src_pix(src_fr, 0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("mis_data", {8'd0, data_ch2, data_ch1, data_ch0}, 32'd0);
        chk("mis_err", {31'd0, err_sticky}, 32'd1);
        run_to(0, 0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("mis_held_de", {31'd0, de}, 32'd1);
        chk("mis_held_data", {8'd0, data_ch2, data_ch1, data_ch0}, {8'd0, held});

        // Underflow and clr_err together: the set wins.
        scyc(1'b1, 1'b1, 1'b1);
        chk("set_beats_clr", {31'd0, err_sticky}, 32'd1);
        scyc(1'b1, 1'b0, 1'b1);
        chk("clr_alone", {31'd0, err_sticky}, 32'd0);

        // enable dropped at (1,2) in RUN.
        for (int i = 0; i < 3 * HT * VT && m_st != 2; i++) scyc(1'b1, 1'b0, 1'b0);
        run_to(1, 2);
        scyc(1'b0, 1'b0, 1'b0);
        chk_quiet("dis");
        scyc(1'b1, 1'b0, 1'b0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("reenable_origin_fs", {31'd0, frame_start}, 32'd1);

        // Asynchronous reset mid-line, right after an underflow set the error.
        for (int i = 0; i < 3 * HT * VT && m_st != 2; i++) scyc(1'b1, 1'b0, 1'b0);
        run_to(2, 1);
        scyc(1'b1, 1'b1, 1'b0);
        chk("pre_rst_err", {31'd0, err_sticky}, 32'd1);
        #2 rst_pix_n = 1'b0;
        #1;
        chk_quiet("rst_mid");
        chk("rst_mid_err", {31'd0, err_sticky}, 32'd0);
        chk("rst_mid_ready", {31'd0, s_ready}, 32'd0);
        model_reset();
        @(posedge clk_pix);
        #1 rst_pix_n = 1'b1;
        scyc(1'b1, 1'b0, 1'b0);
        scyc(1'b1, 1'b0, 1'b0);
        chk("rst_restart_fs", {31'd0, frame_start}, 32'd1);
        for (int i = 0; i < 10; i++) scyc(1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
